// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max window sequencer and its core.
// State encoding plus data constants used by the core and its driver.
package minmax_pkg;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    IDLE = 2'd1,
    ACC  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ALL_ONES = '1;
  localparam logic [DATA_W-1:0] ZERO     = '0;

endpackage

// File: rtl/minmax_result_buf.sv
// One-entry valid/ready holding register for window results.
// A load wins over a same-cycle drain so a fresh result is never dropped.
module minmax_result_buf
  import minmax_pkg::*;
#(
  parameter int MSB = 31
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [MSB:0] load_data,
  input  logic         r_ready,
  output logic         r_valid,
  output logic [MSB:0] r_data
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= (MSB+1)'(ZERO);
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/minmax_window_sequencer.sv
// Stream front-end for the min/max averaging core: cuts samples into
// windows, drives the core controls and returns one result per window.
module minmax_window_sequencer
  import minmax_pkg::*;
#(
  parameter int MSB   = 31,
  parameter int WIN_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [MSB:0]     s_data,
  input  logic [WIN_W-1:0] win_len,
  input  logic             flush,
  output logic             mm_clear,
  output logic             mm_enable,
  output logic             mm_reset,
  output logic [MSB:0]     mm_in,
  input  logic [MSB:0]     mm_out,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [MSB:0]     r_data
);

  state_t           state;
  logic [WIN_W-1:0] cnt;
  logic [WIN_W-1:0] len;
  logic [WIN_W-1:0] eff_len;
  logic [WIN_W-1:0] cur_len;
  logic [WIN_W-1:0] cnt_inc;
  logic             last_q;
  logic             accept;

  assign s_ready = (state != CLR) && !flush
                && !(r_valid && !r_ready);
  assign accept  = s_valid && s_ready;

  // A zero window length behaves as a single-sample window.
  always_comb begin
    eff_len = (win_len == '0) ? WIN_W'(1) : win_len;
    cur_len = (cnt == '0) ? eff_len : len;
    cnt_inc = cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLR;
      mm_clear  <= 1'b1;
      mm_enable <= 1'b0;
      mm_reset  <= 1'b0;
      mm_in     <= (MSB+1)'(ZERO);
      cnt       <= '0;
      len       <= '0;
      last_q    <= 1'b0;
    end else begin
      mm_clear <= 1'b0;
      mm_reset <= 1'b0;
      last_q   <= 1'b0;
      if (flush) begin
        state     <= CLR;
        mm_clear  <= 1'b1;
        mm_enable <= 1'b0;
        cnt       <= '0;
      end else if (accept) begin
        state     <= ACC;
        mm_enable <= 1'b1;
        mm_in     <= s_data;
        mm_reset  <= (cnt == '0);
        if (cnt == '0)
          len <= eff_len;
        if (cnt_inc == cur_len) begin
          cnt    <= '0;
          last_q <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end else if (cnt != '0) begin
        // Mid-window stall: re-present mm_in, keep the core enabled.
        state     <= HOLD;
        mm_enable <= 1'b1;
      end else begin
        state     <= IDLE;
        mm_enable <= 1'b0;
      end
    end
  end

  minmax_result_buf #(
    .MSB (MSB)
  ) u_result_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (last_q),
    .load_data (mm_out),
    .r_ready   (r_ready),
    .r_valid   (r_valid),
    .r_data    (r_data)
  );

endmodule

// File: tb/tb_minmax_window_sequencer.sv
// Bench for minmax_window_sequencer: directed vector table, reset corner,
// then random traffic scored against a window-level reference model.
module tb_minmax_window_sequencer;
  import minmax_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [7:0]  win_len;
  logic        flush;
  logic        mm_clear;
  logic        mm_enable;
  logic        mm_reset;
  logic [31:0] mm_in;
  logic [31:0] mm_out;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;

  int n_checks = 0;
  int n_pass   = 0;

  minmax_window_sequencer #(
    .MSB   (31),
    .WIN_W (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .win_len   (win_len),
    .flush     (flush),
    .mm_clear  (mm_clear),
    .mm_enable (mm_enable),
    .mm_reset  (mm_reset),
    .mm_in     (mm_in),
    .mm_out    (mm_out),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data)
  );

  always #5 clock = ~clock;

  // Behavioural min/max averaging core.
  logic [31:0] c_min  = ALL_ONES;
  logic [31:0] c_max  = '0;
  logic [31:0] c_last = '0;
  logic [31:0] e_mn, e_mx;

  always_comb begin
    e_mn   = c_min;
    e_mx   = c_max;
    mm_out = c_last;
    if (mm_enable) begin
      e_mn   = mm_reset ? mm_in : ((mm_in < c_min) ? mm_in : c_min);
      e_mx   = mm_reset ? mm_in : ((mm_in > c_max) ? mm_in : c_max);
      mm_out = 32'(({1'b0, e_mn} + {1'b0, e_mx}) >> 1);
    end
  end

  always @(posedge clock) begin
    if (mm_clear) begin
      c_min  <= ALL_ONES;
      c_max  <= '0;
      c_last <= '0;
    end else if (mm_enable) begin
      c_min  <= e_mn;
      c_max  <= e_mx;
      c_last <= mm_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d at %0t",
                  name, act, exp, $time);
  endtask

  // Reference model: samples collected per window in a queue.
  bit          m_clr, e_clr, e_en, e_rst, m_rv, cap_now;
  logic [31:0] e_in, m_rd, cap_val;
  logic [31:0] win_q[$];
  int          win_target;

  function automatic logic [31:0] window_avg(input logic [31:0] q[$]);
    logic [31:0] mn, mx;
    mn = q[0];
    mx = q[0];
    foreach (q[k]) begin
      if (q[k] < mn) mn = q[k];
      if (q[k] > mx) mx = q[k];
    end
    return 32'(({1'b0, mn} + {1'b0, mx}) >> 1);
  endfunction

  always @(negedge clock) begin : model
    bit          rdy_e, acc, last, n_rv;
    logic [31:0] n_rd;
    if (!reset_n) begin
      m_clr = 1; e_clr = 1; e_en = 0; e_rst = 0; e_in = '0;
      m_rv = 0; m_rd = '0; cap_now = 0; cap_val = '0;
      win_q.delete();
    end
    rdy_e = !m_clr && !flush && !(m_rv && !r_ready);
    chk("mon_clear", mm_clear, e_clr);
    chk("mon_enable", mm_enable, e_en);
    chk("mon_reset", mm_reset, e_rst);
    if (e_en) chk("mon_in", mm_in, e_in);
    chk("mon_s_ready", s_ready, rdy_e);
    chk("mon_r_valid", r_valid, m_rv);
    if (m_rv) chk("mon_r_data", r_data, m_rd);
    if (reset_n) begin
      acc  = s_valid && rdy_e;
      last = 0;
      n_rv = cap_now ? 1'b1 : (m_rv && !r_ready);
      n_rd = cap_now ? cap_val : m_rd;
      e_en  = !flush && (acc || win_q.size() != 0);
      e_rst = !flush && acc && win_q.size() == 0;
      if (acc) e_in = s_data;
      if (flush) win_q.delete();
      else if (acc) begin
        if (win_q.size() == 0)
          win_target = (win_len == 0) ? 1 : int'(win_len);
        win_q.push_back(s_data);
        if (win_q.size() == win_target) begin
          last    = 1;
          cap_val = window_avg(win_q);
          win_q.delete();
        end
      end
      cap_now = last;
      m_rv    = n_rv;
      m_rd    = n_rd;
      m_clr   = flush;
      e_clr   = flush;
    end
  end

  typedef struct {
    bit          v;
    logic [31:0] d;
    logic [7:0]  wl;
    bit          fl;
    bit          rr;
    bit          e_rdy;
    bit          e_clr;
    bit          e_en;
    bit          e_rst;
    logic [31:0] e_in;
    bit          e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit v, int d, int wl, bit fl, bit rr,
                              bit rdy, bit clr, bit en, bit rst,
                              int in_v, bit rv, int rd);
    vec_t t;
    t.v = v; t.d = d; t.wl = 8'(wl); t.fl = fl; t.rr = rr;
    t.e_rdy = rdy; t.e_clr = clr; t.e_en = en; t.e_rst = rst;
    t.e_in = in_v; t.e_rv = rv; t.e_rd = rd;
    vecs.push_back(t);
  endfunction

  initial begin
    // v  d   wl fl rr | rdy clr en rst in  rv rd
    // back-to-back window of four
    add(1, 10, 4, 0, 1,  1, 0, 0, 0, 0,   0, 0);
    add(1, 50, 4, 0, 1,  1, 0, 1, 1, 10,  0, 0);
    add(1, 30, 4, 0, 1,  1, 0, 1, 0, 50,  0, 0);
    add(1, 20, 4, 0, 1,  1, 0, 1, 0, 30,  0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 1, 0, 20,  0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 0, 0, 0,   1, 30);
    add(0, 0,  4, 0, 1,  1, 0, 0, 0, 0,   0, 0);
    // stall gap after the first sample
    add(1, 10, 4, 0, 1,  1, 0, 0, 0, 0,   0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 1, 1, 10,  0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 1, 0, 10,  0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 1, 0, 10,  0, 0);
    add(1, 50, 4, 0, 1,  1, 0, 1, 0, 10,  0, 0);
    add(1, 30, 4, 0, 1,  1, 0, 1, 0, 50,  0, 0);
    add(1, 20, 4, 0, 1,  1, 0, 1, 0, 30,  0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 1, 0, 20,  0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 0, 0, 0,   1, 30);
    add(0, 0,  4, 0, 1,  1, 0, 0, 0, 0,   0, 0);
    // single-sample windows, win_len 0 acts as 1
    add(1, 7,  1, 0, 1,  1, 0, 0, 0, 0,   0, 0);
    add(1, 9,  0, 0, 1,  1, 0, 1, 1, 7,   0, 0);
    add(0, 0,  1, 0, 1,  1, 0, 1, 1, 9,   1, 7);
    add(0, 0,  1, 0, 1,  1, 0, 0, 0, 0,   1, 9);
    add(0, 0,  1, 0, 1,  1, 0, 0, 0, 0,   0, 0);
    // result held while r_ready is low
    add(1, 4,  2, 0, 0,  1, 0, 0, 0, 0,   0, 0);
    add(1, 8,  2, 0, 0,  1, 0, 1, 1, 4,   0, 0);
    add(0, 0,  2, 0, 0,  1, 0, 1, 0, 8,   0, 0);
    add(1, 99, 2, 0, 0,  0, 0, 0, 0, 0,   1, 6);
    add(1, 99, 2, 0, 0,  0, 0, 0, 0, 0,   1, 6);
    add(0, 0,  2, 0, 1,  1, 0, 0, 0, 0,   1, 6);
    add(0, 0,  2, 0, 1,  1, 0, 0, 0, 0,   0, 0);
    // flush abandons a partial window
    add(1, 100, 4, 0, 1, 1, 0, 0, 0, 0,   0, 0);
    add(1, 200, 4, 0, 1, 1, 0, 1, 1, 100, 0, 0);
    add(0, 0,  4, 1, 1,  0, 0, 1, 0, 200, 0, 0);
    add(0, 0,  4, 0, 1,  0, 1, 0, 0, 0,   0, 0);
    add(1, 1,  4, 0, 1,  1, 0, 0, 0, 0,   0, 0);
    add(1, 3,  4, 0, 1,  1, 0, 1, 1, 1,   0, 0);
    add(1, 5,  4, 0, 1,  1, 0, 1, 0, 3,   0, 0);
    add(1, 7,  4, 0, 1,  1, 0, 1, 0, 5,   0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 1, 0, 7,   0, 0);
    add(0, 0,  4, 0, 1,  1, 0, 0, 0, 0,   1, 4);
    add(0, 0,  4, 0, 1,  1, 0, 0, 0, 0,   0, 0);

    reset_n = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    win_len = 8'd4;
    flush   = 1'b0;
    r_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_clear", mm_clear, 1);
    chk("rst_enable", mm_enable, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("clr_cycle_clear", mm_clear, 1);
    chk("clr_cycle_ready", s_ready, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #2;
      s_valid = vecs[i].v;
      s_data  = vecs[i].d;
      win_len = vecs[i].wl;
      flush   = vecs[i].fl;
      r_ready = vecs[i].rr;
      @(negedge clock);
      chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_clear", i), mm_clear, vecs[i].e_clr);
      chk($sformatf("vec%0d_enable", i), mm_enable, vecs[i].e_en);
      chk($sformatf("vec%0d_reset", i), mm_reset, vecs[i].e_rst);
      if (vecs[i].e_en)
        chk($sformatf("vec%0d_in", i), mm_in, vecs[i].e_in);
      chk($sformatf("vec%0d_r_valid", i), r_valid, vecs[i].e_rv);
      if (vecs[i].e_rv)
        chk($sformatf("vec%0d_r_data", i), r_data, vecs[i].e_rd);
    end

    // Asynchronous reset in the middle of a window.
    @(posedge clock); #2;
    s_valid = 1'b1; s_data = 32'd11; win_len = 8'd4;
    @(posedge clock); #2;
    s_data = 32'd22;
    @(posedge clock); #2;
    s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_clear", mm_clear, 1);
    chk("async_enable", mm_enable, 0);
    chk("async_mm_in", mm_in, 0);
    chk("async_s_ready", s_ready, 0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_clear", mm_clear, 1);
    @(posedge clock); #2;
    s_valid = 1'b1; s_data = 32'd42;
    @(posedge clock); #2;
    s_valid = 1'b0;
    #1;
    chk("post_rst_mm_reset", mm_reset, 1);
    chk("post_rst_mm_in", mm_in, 42);

    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #2;
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = $urandom;
      win_len = 8'($urandom_range(2, 6));
      flush   = ($urandom_range(0, 39) == 0);
      r_ready = ($urandom_range(0, 9) < 6);
    end
    @(posedge clock); #2;
    s_valid = 1'b0; flush = 1'b0; r_ready = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
